// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared state encoding and width defaults for the stall controller
package pipe_stall_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    DIV_RUN = 1'b1
  } state_e;

  localparam int CNT_W_DEF = 32;
  localparam int RA_W_DEF  = 5;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline enable/flush control for memory wait, exceptions,
// multi-cycle divide and load-use hazards, with a stall-cycle counter
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_wait,
  input  logic             except_m,
  input  logic             div_req_e,
  input  logic             div_done,
  input  logic             load_e,
  input  logic [RA_W-1:0]  rt_e,
  input  logic [RA_W-1:0]  rs_d,
  input  logic [RA_W-1:0]  rt_d,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             div_start,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e state_q;
  state_e state_d;
  logic   done_pend_q;
  logic   done_pend_d;
  logic   load_use;

  // $0 is hardwired zero, so a load targeting it never creates a hazard
  assign load_use = load_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));

  always_comb begin
    state_d     = state_q;
    done_pend_d = done_pend_q;
    en_f        = 1'b1;
    en_d        = 1'b1;
    en_e        = 1'b1;
    en_m        = 1'b1;
    en_w        = 1'b1;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    div_start   = 1'b0;

    if (!resetn) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
    end else if (mem_wait) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
      // Remember a completion that lands during the freeze so it is not lost
      if ((state_q == DIV_RUN) && div_done) begin
        done_pend_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (except_m) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
          end else if (div_req_e) begin
            div_start = 1'b1;
            en_f      = 1'b0;
            en_d      = 1'b0;
            en_e      = 1'b0;
            flush_m   = 1'b1;
            state_d   = DIV_RUN;
          end else if (load_use) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            flush_e = 1'b1;
          end
        end
        DIV_RUN: begin
          if (div_done || done_pend_q) begin
            done_pend_d = 1'b0;
            state_d     = IDLE;
          end else begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            en_e    = 1'b0;
            flush_m = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign busy = resetn && (state_q == DIV_RUN);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (!en_f),
    .q      (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - table-driven and sequence checks of pipe_stall_ctrl with a scoreboard
module tb_pipe_stall_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 8;

  // expected output bundle: en f d e m w, flush d e m, div_start, busy
  localparam logic [9:0] OK_I  = 10'b11111_000_0_0;
  localparam logic [9:0] OK_R  = 10'b11111_000_0_1;
  localparam logic [9:0] LU    = 10'b00111_010_0_0;
  localparam logic [9:0] EX    = 10'b11111_111_0_0;
  localparam logic [9:0] FRZ_I = 10'b00000_000_0_0;
  localparam logic [9:0] FRZ_R = 10'b00000_000_0_1;
  localparam logic [9:0] START = 10'b00011_001_1_0;
  localparam logic [9:0] RUN   = 10'b00011_001_0_1;
  localparam logic [9:0] RST   = 10'b00000_000_0_0;

  logic             clk = 1'b0;
  logic             resetn;
  logic             mem_wait, except_m, div_req_e, div_done, load_e;
  logic [RA_W-1:0]  rt_e, rs_d, rt_d;
  logic             en_f, en_d, en_e, en_m, en_w;
  logic             flush_d, flush_e, flush_m, div_start, busy;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .CNT_W (CNT_W),
    .RA_W  (RA_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_wait  (mem_wait),
    .except_m  (except_m),
    .div_req_e (div_req_e),
    .div_done  (div_done),
    .load_e    (load_e),
    .rt_e      (rt_e),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .en_f      (en_f),
    .en_d      (en_d),
    .en_e      (en_e),
    .en_m      (en_m),
    .en_w      (en_w),
    .flush_d   (flush_d),
    .flush_e   (flush_e),
    .flush_m   (flush_m),
    .div_start (div_start),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic            r, mw, ex, dr, dd, ld;
    logic [RA_W-1:0] rte, rsd, rtd;
    logic [9:0]      exp;
  } vec_t;

  logic [9+CNT_W:0] sb_q[$];
  int               pass_cnt = 0;
  int               total    = 0;
  logic [CNT_W-1:0] exp_cnt  = '0;
  vec_t             tbl[10];
  string            tnm[10];

  function automatic vec_t mk(input logic r, mw, ex, dr, dd, ld,
                              input int rte, rsd, rtd, input logic [9:0] e);
    vec_t v;
    v.r = r; v.mw = mw; v.ex = ex; v.dr = dr; v.dd = dd; v.ld = ld;
    v.rte = RA_W'(rte); v.rsd = RA_W'(rsd); v.rtd = RA_W'(rtd);
    v.exp = e;
    return v;
  endfunction

  task automatic step(input string nm, input vec_t v);
    logic [9+CNT_W:0] e;
    logic [9:0]       act;
    resetn = v.r; mem_wait = v.mw; except_m = v.ex; div_req_e = v.dr;
    div_done = v.dd; load_e = v.ld; rt_e = v.rte; rs_d = v.rsd; rt_d = v.rtd;
    if (!v.r) exp_cnt = '0;
    sb_q.push_back({v.exp, exp_cnt});
    @(negedge clk);
    e   = sb_q.pop_front();
    act = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m, div_start, busy};
    total++;
    if (act === e[9+CNT_W:CNT_W]) pass_cnt++;
    else $display("FAIL %s outputs: got %b want %b", nm, act, e[9+CNT_W:CNT_W]);
    total++;
    if (stall_cnt === e[CNT_W-1:0]) pass_cnt++;
    else $display("FAIL %s stall_cnt: got %0d want %0d", nm, stall_cnt, e[CNT_W-1:0]);
    @(posedge clk);
    #1;
    if (v.r && !v.exp[9] && (exp_cnt != '1)) exp_cnt++;
  endtask

  initial begin
    resetn = 1'b0; mem_wait = 1'b0; except_m = 1'b0; div_req_e = 1'b0;
    div_done = 1'b0; load_e = 1'b0; rt_e = '0; rs_d = '0; rt_d = '0;

    tnm[0] = "reset";       tbl[0] = mk(0, 0, 0, 1, 0, 1, 8, 8, 0, RST);
    tnm[1] = "idle";        tbl[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, OK_I);
    tnm[2] = "lu_rs";       tbl[2] = mk(1, 0, 0, 0, 0, 1, 8, 8, 0, LU);
    tnm[3] = "lu_zero";     tbl[3] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, OK_I);
    tnm[4] = "lu_rt";       tbl[4] = mk(1, 0, 0, 0, 0, 1, 5, 3, 5, LU);
    tnm[5] = "no_load";     tbl[5] = mk(1, 0, 0, 0, 0, 0, 8, 8, 8, OK_I);
    tnm[6] = "lu_mismatch"; tbl[6] = mk(1, 0, 0, 0, 0, 1, 8, 7, 6, OK_I);
    tnm[7] = "exc";         tbl[7] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, EX);
    tnm[8] = "exc_div";     tbl[8] = mk(1, 0, 1, 1, 0, 1, 8, 8, 8, EX);
    tnm[9] = "frz_exc";     tbl[9] = mk(1, 1, 1, 1, 0, 1, 8, 8, 8, FRZ_I);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) step(tnm[i], tbl[i]);

    // divide released by div_done, except_m ignored while running
    step("div_start", mk(1, 0, 0, 1, 0, 1, 8, 8, 0, START));
    for (int i = 1; i < 10; i++)
      step("div_run", mk(1, 0, (i == 3), 1, 0, 0, 0, 0, 0, RUN));
    step("div_release", mk(1, 0, 0, 1, 1, 0, 0, 0, 0, OK_R));
    step("div_after", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, OK_I));

    // divide finishing under mem_wait, released through done_pend
    step("mw_div_req", mk(1, 1, 0, 1, 0, 0, 0, 0, 0, FRZ_I));
    step("mw_div_start", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, START));
    step("mw_div_run", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, RUN));
    step("mw_div_run", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, RUN));
    step("mw_done", mk(1, 1, 0, 1, 1, 0, 0, 0, 0, FRZ_R));
    step("mw_hold", mk(1, 1, 1, 1, 0, 0, 0, 0, 0, FRZ_R));
    step("mw_hold", mk(1, 1, 0, 1, 0, 0, 0, 0, 0, FRZ_R));
    step("pend_release", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, OK_R));
    step("pend_after", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, OK_I));

    // done_pend must be cleared: next divide waits for its own div_done
    step("div2_start", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, START));
    step("div2_run", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, RUN));
    step("div2_release", mk(1, 0, 0, 1, 1, 0, 0, 0, 0, OK_R));
    step("div2_after", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, OK_I));

    // counter saturation under a long freeze
    for (int i = 0; i < 260; i++)
      step("sat_freeze", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, FRZ_I));
    step("sat_idle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, OK_I));

    // reset mid-divide abandons it
    step("rd_start", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, START));
    step("rd_run", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, RUN));
    step("rd_reset", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, RST));
    step("rd_reset", mk(0, 0, 0, 1, 1, 0, 0, 0, 0, RST));
    step("rd_stray_done", mk(1, 0, 0, 0, 1, 0, 0, 0, 0, OK_I));
    step("rd_idle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, OK_I));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
